data_memory_ctrl: RTL and testbench

Request-side controller that sits directly upstream of `data_memory` (32 × 64-bit, synchronous write, combinational read) and is its only driver. It accepts load/store requests over a valid/ready handshake and buffers them in a small FIFO. It sequences each request onto the memory ports with exactly one access cycle and returns one response per request: load data, or a store acknowledge. It isolates the datapath from memory timing, so the memory port is never driven by more than one requester per cycle.

---
 rtl/data_memory_ctrl.sv | 140 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: queues load/store requests in a small FIFO and
// sequences them onto data_memory, one access cycle per request.
module data_memory_ctrl #(
    parameter int WORDSIZE = 64,
    parameter int ADDRW    = 5,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDRW-1:0]    req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_write,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic [ADDRW-1:0]    mem_addr,
    output logic [WORDSIZE-1:0] mem_data_input,
    output logic                mem_write_enable,
    output logic                mem_read,
    input  logic [WORDSIZE-1:0] mem_data_output
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic                fifo_write [DEPTH];
    logic [ADDRW-1:0]    fifo_addr  [DEPTH];
    logic [WORDSIZE-1:0] fifo_wdata [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          op_write;
    logic          not_empty;

    // ready comes from the registered count, so a pop frees a slot next cycle
    assign req_ready = (count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign not_empty = (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= req_write;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (not_empty) begin
                    pop        = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (not_empty) begin
                        pop        = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // mem_addr/mem_data_input double as the current-op registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            mem_addr       <= '0;
            mem_data_input <= '0;
            resp_write     <= 1'b0;
            resp_rdata     <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                op_write <= fifo_write[rd_ptr];
                mem_addr <= fifo_addr[rd_ptr];
                if (fifo_write[rd_ptr]) begin
                    mem_data_input <= fifo_wdata[rd_ptr];
                end
            end
            if (state == ACCESS) begin
                resp_write <= op_write;
                resp_rdata <= op_write ? '0 : mem_data_output;
            end
        end
    end

    assign mem_write_enable = (state == ACCESS) && op_write;
    assign mem_read         = (state == ACCESS) && !op_write;
    assign resp_valid       = (state == RESP);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: behavioural data_memory plus an in-order
// request model that applies each op when its response is consumed.
module tb_data_memory_ctrl;
    localparam int W  = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_write;
    logic [W-1:0]  resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_data_input;
    logic          mem_write_enable;
    logic          mem_read;
    logic [W-1:0]  mem_data_output;

    always #5 clk = ~clk;

    data_memory_ctrl #(.WORDSIZE(W), .ADDRW(AW), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_write(resp_write),
        .resp_rdata(resp_rdata),
        .mem_addr(mem_addr),
        .mem_data_input(mem_data_input),
        .mem_write_enable(mem_write_enable),
        .mem_read(mem_read),
        .mem_data_output(mem_data_output)
    );

    logic [W-1:0] mem_array [32];
    always @(posedge clk) begin
        if (mem_write_enable) mem_array[mem_addr] <= mem_data_input;
    end
    assign mem_data_output = mem_array[mem_addr];

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } req_t;

    req_t         pend_q[$];
    logic [W-1:0] ref_mem [32];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int we_cycles = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_enable) we_cycles <= we_cycles + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_front();
        if (pend_q.size() == 0) return '0;
        return pend_q[0].write ? '0 : ref_mem[pend_q[0].addr];
    endfunction

    task automatic send(input logic w, input logic [AW-1:0] a,
                        input logic [W-1:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkb("send_ready", req_ready, 1'b1);
        if (req_ready) begin
            @(posedge clk);
            pend_q.push_back('{write: w, addr: a, data: d});
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic recv(input int stall);
        req_t r;
        logic [W-1:0] exp_d;
        int n = 0;
        resp_ready = 1'b0;
        repeat (stall) @(negedge clk);
        resp_ready = 1'b1;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkb("resp_valid", resp_valid, 1'b1);
        tests++;
        assert (pend_q.size() != 0) else begin
            fails++;
            $error("FAIL resp_unexpected: observed response expected none");
        end
        if (resp_valid && pend_q.size() != 0) begin
            r = pend_q.pop_front();
            if (r.write) begin
                ref_mem[r.addr] = r.data;
                exp_d = '0;
            end else begin
                exp_d = ref_mem[r.addr];
            end
            chkb("resp_write", resp_write, r.write);
            chk("resp_rdata", resp_rdata, exp_d);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int acc;
        int t0;
        int t1;
        int n;
        logic ok;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem_array[i] = '0;
            ref_mem[i]   = '0;
        end
        repeat (2) @(negedge clk);
        chkb("rst_req_ready", req_ready, 1'b1);
        chkb("rst_resp_valid", resp_valid, 1'b0);
        chkb("rst_resp_write", resp_write, 1'b0);
        chk("rst_resp_rdata", resp_rdata, '0);
        chk("rst_mem_addr", W'(mem_addr), '0);
        chk("rst_mem_din", mem_data_input, '0);
        chkb("rst_mem_we", mem_write_enable, 1'b0);
        chkb("rst_mem_read", mem_read, 1'b0);
        reset = 1'b0;

        // store then load, with latency and single write pulse
        w0 = we_cycles;
        send(1'b1, 5'd5, 64'hAAAA_AAAA_AAAA_AAAA);
        chkb("lat_k_we", mem_write_enable, 1'b0);
        chkb("lat_k_valid", resp_valid, 1'b0);
        @(negedge clk);
        chkb("access_we", mem_write_enable, 1'b1);
        chkb("access_read", mem_read, 1'b0);
        chk("access_addr", W'(mem_addr), 64'd5);
        chk("access_din", mem_data_input, 64'hAAAA_AAAA_AAAA_AAAA);
        @(negedge clk);
        chkb("lat_valid", resp_valid, 1'b1);
        chkb("resp_we_low", mem_write_enable, 1'b0);
        recv(0);
        send(1'b0, 5'd5, '0);
        recv(0);
        chk("we_pulses", W'(we_cycles - w0), 64'd1);

        // overwrite, pipelined
        fork
            begin
                send(1'b1, 5'd5, '0);
                send(1'b1, 5'd1, '1);
                send(1'b0, 5'd5, '0);
                send(1'b0, 5'd1, '0);
            end
            begin
                repeat (4) recv(0);
            end
        join

        // full FIFO under backpressure
        resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_write = (i == 0 || i == 3);
            req_addr  = (i == 2) ? 5'd1 : ((i == 3) ? 5'd7 : 5'd3);
            req_wdata = {$urandom, $urandom};
            ok = req_ready;
            @(posedge clk);
            if (ok) begin
                pend_q.push_back('{write: req_write, addr: req_addr,
                                   data: req_wdata});
                acc++;
            end
            @(negedge clk);
        end
        chk("full_accepted", W'(acc), 64'd3);
        chkb("full_ready_low", req_ready, 1'b0);
        chkb("full_resp_held", resp_valid, 1'b1);
        req_valid = 1'b0;
        repeat (3) recv(0);
        repeat (2) @(negedge clk);
        chkb("full_no_extra", resp_valid, 1'b0);

        // response backpressure on a load
        resp_ready = 1'b0;
        send(1'b0, 5'd1, '0);
        n = 0;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chkb("bp_valid", resp_valid, 1'b1);
            chk("bp_rdata", resp_rdata, exp_front());
            chkb("bp_no_read", mem_read, 1'b0);
            chkb("bp_no_write", mem_write_enable, 1'b0);
            @(negedge clk);
        end
        recv(0);

        // reset during the ACCESS cycle of a store
        resp_ready = 1'b1;
        w0 = we_cycles;
        send(1'b1, 5'd5, 64'h0FFF_FFFF_FFFF_FFF0);
        @(negedge clk);
        chkb("rst_pre_we", mem_write_enable, 1'b1);
        #1 reset = 1'b1;
        #1;
        chkb("rst_we_drop", mem_write_enable, 1'b0);
        pend_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chkb("rst_no_resp", resp_valid, 1'b0);
        end
        chk("rst_no_write", W'(we_cycles - w0), '0);
        send(1'b0, 5'd5, '0);
        recv(0);

        // random mix with random response stalls
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                         {$urandom, $urandom});
                end
            end
            begin
                for (int i = 0; i < 20; i++) recv($urandom_range(0, 3));
            end
        join

        // streaming loads
        resp_ready = 1'b1;
        t0 = 0;
        t1 = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(1'b0, AW'(i), '0);
                end
            end
            begin
                n = 0;
                while (!mem_read && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                t0 = cyc;
                repeat (8) recv(0);
                t1 = cyc;
            end
        join
        chkb("stream_within_16", (t1 - t0) <= 16, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
